coincidence_stimulus_gen: RTL and testbench
===========================================

# coincidence_stimulus_gen

Synthetic muon-event source for bring-up and self-test of the lifetime measurement path. Emits a start pulse (`coincidence`), then, after a programmed or pseudo-random delay, a stop pulse (`stop_out`); these drive the TDC's coincidence and stop inputs in place of the detector front end and button. Delays are latched and reported so the measured value can be checked against the true one.

## Interface
- `PULSE_CYCLES`, 4: width of both `coincidence` and `stop_out` pulses, in clk cycles (≥1).
- `HOLDOFF_CYCLES`, 64: dead time after stop pulse ends before the next event may start (≥1).
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `enable` in 1: free-run; start a new event whenever idle.
- `trigger` in 1: single-shot start request; level-sampled while idle.
- `mode` in 1: 0 = delay from `fixed_delay`; 1 = pseudo-random delay.
- `fixed_delay` in 16: requested start-to-stop delay, in cycles.
- `delay_mask` in 16: random delay = LFSR state AND `delay_mask`.
- `coincidence` out 1: start pulse, registered.
- `stop_out` out 1: stop pulse, registered.
- `busy` out 1: high whenever the FSM is not IDLE.
- `last_delay` out 16: effective delay D_eff of the most recently accepted event.
- `event_count` out 16: number of accepted events, wraps modulo 2^16.

## Operation
- **FSM states:** IDLE, ARM, START, WAIT, STOP, HOLDOFF.
- **Accept:** in IDLE, a clock edge with `enable`|`trigger` high accepts an event. `trigger` outside IDLE is ignored, not queued.
- **On accept:**
  - Raw delay D = `mode` ? (lfsr & `delay_mask`) : `fixed_delay`, using the LFSR value at the accepting edge.
  - D_eff = 0 if D = 0; otherwise D_eff = max(D, `PULSE_CYCLES`).
  - Latch D_eff into `last_delay`; increment `event_count`; go to ARM.
- **ARM:** one cycle → START.
- **START:** `coincidence` high for `PULSE_CYCLES` cycles.
  - If D_eff = 0 → HOLDOFF. This is a no-stop event; it exercises the TDC timeout.
  - Otherwise → WAIT.
- **WAIT:** D_eff − `PULSE_CYCLES` cycles (0 allowed) → STOP.
- **STOP:** `stop_out` high for `PULSE_CYCLES` cycles → HOLDOFF.
- **HOLDOFF:** `HOLDOFF_CYCLES` cycles → IDLE.
- **LFSR:** 16-bit Galois, taps mask 16'hB400, shifts every cycle regardless of state.
- **Counters:** one 16-bit elapsed counter plus one phase counter; no arithmetic overflow is possible inside an event.
- **Input sampling:** `mode`, `fixed_delay` and `delay_mask` are sampled only at acceptance; changes mid-event have no effect.
- **Reset:** asynchronous, at any time, including mid-pulse.
  - FSM to IDLE; LFSR to `LFSR_SEED`.
  - `coincidence`, `stop_out`, `busy` = 0; `last_delay` = 0; `event_count` = 0.

## Timing
- Accepting edge E.
- `busy` rises at E.
- `coincidence` rises at E+1 and falls at E+1+P (P = `PULSE_CYCLES`).
- `stop_out` rises at E+1+D_eff and falls at E+1+D_eff+P. The start-to-stop rising-edge spacing is exactly D_eff.
- `busy` falls at E+1+D_eff+P+H (H = `HOLDOFF_CYCLES`). For D_eff = 0, `busy` falls at E+1+P+H.
- The earliest next accepting edge is the first edge with `busy` low. The free-run coincidence period is D_eff+P+H+2 cycles.
- `last_delay` and `event_count` update at E and are stable for the whole event.
- `event_count` at 16'hFFFF wraps to 0 on the next accept.

## Structure
- **Package `stim_pkg`:** FSM state enum, LFSR tap constant 16'hB400, delay width constant 16.
- **Sub-module `lfsr16`:** LFSR register with seed parameter; inputs clk and rst_n, output 16-bit state.
- **Top:** FSM, counters, and output registers.

## Test plan
All scenarios use P=4, H=64.
- **Fixed delay:** `fixed_delay`=100, one-cycle `trigger` at E → `coincidence` high E+1..E+4; `stop_out` rises at E+101 and stays high for 4 cycles; `busy` falls at E+169; `last_delay`=100; `event_count`=1.
- **Clamp:** `fixed_delay`=2 → `stop_out` rises at E+5; `last_delay`=4.
- **No-stop:** `fixed_delay`=0 → no `stop_out` pulse; `busy` falls at E+69; `last_delay`=0.
- **Free-run:** `enable`=1, `fixed_delay`=100 → `coincidence` rising edges exactly 170 cycles apart. A `trigger` pulse during `busy` causes no extra event and no count change.
- **Random mode:** `mode`=1, `delay_mask`=16'h00FF, 50 events.
  - Each `last_delay` equals a software Galois-LFSR model (seed 16'hACE1), masked and clamped.
  - All values ≤255, and ≥4 or 0.
  - Measured start-to-stop spacing equals `last_delay`.
- **Reset:** `rst_n` low during WAIT → all outputs 0 within the same cycle, with no clk edge needed. After release, the first random delay matches the model restarted from the seed.

Source files
------------

// File: rtl/stim_pkg.sv
// Shared types and constants for the synthetic coincidence/stop event generator.
`timescale 1ns/1ps
package stim_pkg;
  localparam int          DELAY_W   = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_START, S_WAIT, S_STOP, S_HOLDOFF
  } state_t;

  // A nonzero delay shorter than the pulse would overlap start and stop pulses.
  function automatic logic [DELAY_W-1:0] eff_delay(input logic [DELAY_W-1:0] raw,
                                                    input logic [DELAY_W-1:0] min_d);
    if (raw == '0)       return '0;
    else if (raw < min_d) return min_d;
    else                  return raw;
  endfunction
endpackage

// File: rtl/coincidence_stimulus_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR (right-shifting) used as the random delay source.
`timescale 1ns/1ps
module lfsr16
  import stim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_state
);
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= SEED;
    else        r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  assign o_state = r_lfsr;
endmodule

// File: rtl/coincidence_stimulus_gen.sv
// Synthetic muon-event source: start pulse, programmed/random delay, stop pulse, holdoff.
`timescale 1ns/1ps
module coincidence_stimulus_gen
  import stim_pkg::*;
#(
  parameter int          PULSE_CYCLES   = 4,
  parameter int          HOLDOFF_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               trigger,
  input  logic               mode,
  input  logic [DELAY_W-1:0] fixed_delay,
  input  logic [DELAY_W-1:0] delay_mask,
  output logic               coincidence,
  output logic               stop_out,
  output logic               busy,
  output logic [DELAY_W-1:0] last_delay,
  output logic [15:0]        event_count
);
  localparam int PH_MAX = (HOLDOFF_CYCLES > PULSE_CYCLES) ? HOLDOFF_CYCLES : PULSE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]    PH_PULSE = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0]    PH_HOLD  = PH_W'(HOLDOFF_CYCLES - 1);
  localparam logic [DELAY_W-1:0] P_D      = DELAY_W'(PULSE_CYCLES);

  state_t             r_state;
  logic [PH_W-1:0]    r_phase;
  logic [DELAY_W-1:0] r_elapsed;
  logic               r_coinc;
  logic               r_stop;
  logic [DELAY_W-1:0] r_last_delay;
  logic [15:0]        r_count;

  logic [15:0]        w_lfsr;
  logic               w_accept;
  logic [DELAY_W-1:0] w_raw;
  logic [DELAY_W-1:0] w_deff;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_state (w_lfsr)
  );

  assign w_accept = (r_state == S_IDLE) && (enable || trigger);
  assign w_raw    = mode ? (w_lfsr & delay_mask) : fixed_delay;
  assign w_deff   = eff_delay(w_raw, P_D);

  // r_last_delay doubles as the in-flight D_eff, so inputs are only sampled at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_elapsed    <= '0;
      r_coinc      <= 1'b0;
      r_stop       <= 1'b0;
      r_last_delay <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last_delay <= w_deff;
            r_count      <= r_count + 16'd1;
            r_state      <= S_ARM;
          end
        end
        S_ARM: begin
          r_coinc <= 1'b1;
          r_phase <= PH_PULSE;
          r_state <= S_START;
        end
        S_START: begin
          if (r_phase == '0) begin
            r_coinc <= 1'b0;
            if (r_last_delay == '0) begin
              r_phase <= PH_HOLD;
              r_state <= S_HOLDOFF;
            end else if (r_last_delay == P_D) begin
              // Stop must rise on the very edge the start pulse ends.
              r_stop  <= 1'b1;
              r_phase <= PH_PULSE;
              r_state <= S_STOP;
            end else begin
              r_elapsed <= r_last_delay - P_D - DELAY_W'(1);
              r_state   <= S_WAIT;
            end
          end else begin
            r_phase <= r_phase - PH_W'(1);
          end
        end
        S_WAIT: begin
          if (r_elapsed == '0) begin
            r_stop  <= 1'b1;
            r_phase <= PH_PULSE;
            r_state <= S_STOP;
          end else begin
            r_elapsed <= r_elapsed - DELAY_W'(1);
          end
        end
        S_STOP: begin
          if (r_phase == '0) begin
            r_stop  <= 1'b0;
            r_phase <= PH_HOLD;
            r_state <= S_HOLDOFF;
          end else begin
            r_phase <= r_phase - PH_W'(1);
          end
        end
        S_HOLDOFF: begin
          if (r_phase == '0) r_state <= S_IDLE;
          else               r_phase <= r_phase - PH_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign coincidence = r_coinc;
  assign stop_out    = r_stop;
  assign busy        = (r_state != S_IDLE);
  assign last_delay  = r_last_delay;
  assign event_count = r_count;
endmodule

// File: tb/tb_coincidence_stimulus_gen.sv
// Directed bench for coincidence_stimulus_gen: event timing, clamp, no-stop, free-run, random, reset.
`timescale 1ns/1ps
module tb_coincidence_stimulus_gen;
  localparam int P = 4;
  localparam int H = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] fixed_delay = '0;
  logic [15:0] delay_mask = '0;
  logic        coincidence, stop_out, busy;
  logic [15:0] last_delay, event_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ev_exp   = 0;

  coincidence_stimulus_gen #(
    .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .trigger     (trigger),
    .mode        (mode),
    .fixed_delay (fixed_delay),
    .delay_mask  (delay_mask),
    .coincidence (coincidence),
    .stop_out    (stop_out),
    .busy        (busy),
    .last_delay  (last_delay),
    .event_count (event_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference Galois LFSR, right shift with taps 16'hB400.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Edge monitor: timestamps (in posedge index) of output transitions.
  int t_crise = -1, t_cfall = -1, t_srise = -1, t_sfall = -1, t_bfall = -1;
  int n_srise = 0;
  int crise_q[$];
  logic p_c = 1'b0, p_s = 1'b0, p_b = 1'b0;
  always @(negedge clk) begin
    if (coincidence && !p_c) begin t_crise = cyc; crise_q.push_back(cyc); end
    if (!coincidence && p_c) t_cfall = cyc;
    if (stop_out && !p_s) begin t_srise = cyc; n_srise++; end
    if (!stop_out && p_s) t_sfall = cyc;
    if (!busy && p_b) t_bfall = cyc;
    p_c = coincidence; p_s = stop_out; p_b = busy;
  end

  logic [15:0] exp_q[$];

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_event(input string tag, input logic m, input logic [15:0] fd,
                          input logic [15:0] msk);
    logic [15:0] raw, expd, d;
    int e, ns0;
    raw  = m ? (m_lfsr & msk) : fd;
    expd = (raw == 16'd0) ? 16'd0 : ((raw < 16'(P)) ? 16'(P) : raw);
    exp_q.push_back(expd);
    mode = m; fixed_delay = fd; delay_mask = msk; trigger = 1'b1;
    ns0 = n_srise;
    tick();
    trigger = 1'b0;
    e = cyc;
    ev_exp++;
    chk({tag, ".busy_rise"}, {31'd0, busy}, 32'd1);
    chk({tag, ".count"}, {16'd0, event_count}, 32'(ev_exp & 32'hFFFF));
    for (int i = 0; i < 2000 && busy; i++) tick();
    chk({tag, ".timeout"}, {31'd0, busy}, 32'd0);
    d = exp_q.pop_front();
    chk({tag, ".last_delay"}, {16'd0, last_delay}, {16'd0, d});
    chk({tag, ".coinc_rise"}, t_crise, e + 1);
    chk({tag, ".coinc_fall"}, t_cfall, e + 1 + P);
    if (d != 16'd0) begin
      chk({tag, ".stop_rise"}, t_srise, e + 1 + int'(d));
      chk({tag, ".stop_fall"}, t_sfall, e + 1 + int'(d) + P);
      chk({tag, ".spacing"}, t_srise - t_crise, {16'd0, last_delay});
      chk({tag, ".stop_cnt"}, n_srise - ns0, 1);
    end else begin
      chk({tag, ".no_stop"}, n_srise - ns0, 0);
    end
    chk({tag, ".busy_fall"}, t_bfall, e + 1 + int'(d) + P + H);
    if (m) chk({tag, ".range"},
               {31'd0, (last_delay <= 16'd255) && (last_delay >= 16'(P) || last_delay == 16'd0)},
               32'd1);
    tick();
  endtask

  initial begin
    int n0;
    repeat (3) tick();
    chk("rst.coinc", {31'd0, coincidence}, 0);
    chk("rst.stop",  {31'd0, stop_out}, 0);
    chk("rst.busy",  {31'd0, busy}, 0);
    chk("rst.last",  {16'd0, last_delay}, 0);
    chk("rst.count", {16'd0, event_count}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    do_event("fixed100", 1'b0, 16'd100, 16'h0000);
    do_event("clamp2",   1'b0, 16'd2,   16'h0000);
    do_event("clamp4",   1'b0, 16'd4,   16'h0000);
    do_event("nostop",   1'b0, 16'd0,   16'h0000);

    // Free-run with a stray trigger while busy.
    n0 = ev_exp;
    crise_q.delete();
    mode = 1'b0; fixed_delay = 16'd100; enable = 1'b1;
    for (int i = 0; i < 2000 && crise_q.size() < 3; i++) begin
      trigger = (i == 60);
      tick();
    end
    trigger = 1'b0;
    enable  = 1'b0;
    for (int i = 0; i < 2000 && busy; i++) tick();
    chk("free.timeout", {31'd0, busy}, 0);
    chk("free.events", crise_q.size(), 3);
    if (crise_q.size() >= 3) begin
      chk("free.period01", crise_q[1] - crise_q[0], 170);
      chk("free.period12", crise_q[2] - crise_q[1], 170);
    end
    ev_exp = n0 + 3;
    chk("free.count", {16'd0, event_count}, 32'(ev_exp));
    chk("free.last",  {16'd0, last_delay}, 100);
    tick();

    for (int k = 0; k < 50; k++) do_event("random", 1'b1, 16'd0, 16'h00FF);

    // Asynchronous reset mid-WAIT.
    mode = 1'b0; fixed_delay = 16'd100; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (20) tick();
    chk("mid.busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst.coinc", {31'd0, coincidence}, 0);
    chk("arst.stop",  {31'd0, stop_out}, 0);
    chk("arst.busy",  {31'd0, busy}, 0);
    chk("arst.last",  {16'd0, last_delay}, 0);
    chk("arst.count", {16'd0, event_count}, 0);
    tick();
    rst_n = 1'b1;
    ev_exp = 0;
    do_event("post_rst_rand", 1'b1, 16'd0, 16'h00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
